// File: rtl/rf_pkg.sv
// rf_pkg: shared definitions for the rf_sync register file.
//   WM_*    : write-mode encodings carried on wr_mode
//   state_t : sequencer states (idle / clear sweep)
package rf_pkg;

  localparam logic [1:0] WM_FULL  = 2'b00;
  localparam logic [1:0] WM_UPPER = 2'b01;
  localparam logic [1:0] WM_LOWER = 2'b10;
  localparam logic [1:0] WM_RSVD  = 2'b11;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/rf_wmerge.sv
// rf_wmerge: combinational write-merge of new data into an existing word.
//   old     in  DW  current register contents
//   wr_data in  DW  incoming write data (half modes use its lower half)
//   wr_mode in  2   FULL / UPPER / LOWER / reserved
//   merged  out DW  word the register would hold after the write
module rf_wmerge
  import rf_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] old,
  input  logic [DW-1:0] wr_data,
  input  logic [1:0]    wr_mode,
  output logic [DW-1:0] merged
);

  localparam int HW = DW / 2;

  logic [DW-1:0] merged_s;

  // Select which half (or both) of the word the new data replaces.
  always_comb begin
    merged_s = old;
    case (wr_mode)
      WM_FULL:  merged_s = wr_data;
      WM_UPPER: merged_s = {wr_data[HW-1:0], old[HW-1:0]};
      WM_LOWER: merged_s = {old[DW-1:HW], wr_data[HW-1:0]};
      default:  merged_s = old;
    endcase
  end

  assign merged = merged_s;

endmodule

// File: rtl/rf_sync.sv
// rf_sync: clocked register file with half-word write modes, optional
// write-to-read bypass, a one-cycle done pulse and a sequenced clear sweep.
// Register 0 always reads zero.
//   clk, rst_n           clock, asynchronous active-low reset
//   rd_addr_x/rd_addr_y  read addresses; rd_x/rd_y combinational read data
//   req, wr_en, wr_mode, wr_addr, wr_data   operation strobe and write port
//   clr                  start a clear sweep of registers 1..NREGS-1
//   busy                 sweep in progress (requests ignored)
//   done                 one-cycle pulse after each accepted request / sweep
module rf_sync
  import rf_pkg::*;
#(
  parameter int DW     = 32,
  parameter int NREGS  = 32,
  parameter int AW     = $clog2(NREGS),
  parameter int BYPASS = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rd_addr_x,
  input  logic [AW-1:0] rd_addr_y,
  output logic [DW-1:0] rd_x,
  output logic [DW-1:0] rd_y,
  input  logic          req,
  input  logic          wr_en,
  input  logic [1:0]    wr_mode,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          clr,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] CNT_LAST = AW'(NREGS - 1);
  localparam logic [AW-1:0] CNT_ONE  = AW'(1);

  logic [DW-1:0] regs_r [NREGS];
  state_t        state_r;
  logic [AW-1:0] cnt_r;
  logic          done_r;

  logic          idle_s;
  logic          accept_s;
  logic          write_s;
  logic          sweep_last_s;
  logic [DW-1:0] merged_s;
  logic [DW-1:0] rd_x_s;
  logic [DW-1:0] rd_y_s;

  assign idle_s       = (state_r == S_IDLE);
  // clr has priority over req in the same idle cycle.
  assign accept_s     = req && idle_s && !clr;
  assign write_s      = accept_s && wr_en && (wr_addr != '0) && (wr_mode != WM_RSVD);
  assign sweep_last_s = (state_r == S_CLEAR) && (cnt_r == CNT_LAST);

  // Single merge unit feeds both the write path and the bypass.
  rf_wmerge #(.DW(DW)) u_wmerge (
    .old     (regs_r[wr_addr]),
    .wr_data (wr_data),
    .wr_mode (wr_mode),
    .merged  (merged_s)
  );

  // Read port X: zero register, optional forwarding of the pending write.
  always_comb begin
    rd_x_s = regs_r[rd_addr_x];
    if (rd_addr_x == '0) begin
      rd_x_s = '0;
    end else if ((BYPASS != 0) && write_s && (rd_addr_x == wr_addr)) begin
      rd_x_s = merged_s;
    end else begin
      rd_x_s = regs_r[rd_addr_x];
    end
  end

  // Read port Y: same selection as port X.
  always_comb begin
    rd_y_s = regs_r[rd_addr_y];
    if (rd_addr_y == '0) begin
      rd_y_s = '0;
    end else if ((BYPASS != 0) && write_s && (rd_addr_y == wr_addr)) begin
      rd_y_s = merged_s;
    end else begin
      rd_y_s = regs_r[rd_addr_y];
    end
  end

  // Storage array: sweep clear or accepted write (mutually exclusive by state).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= '0;
      end
    end else if (state_r == S_CLEAR) begin
      regs_r[cnt_r] <= '0;
    end else if (write_s) begin
      regs_r[wr_addr] <= merged_s;
    end
  end

  // Sequencer, sweep counter and registered done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      cnt_r   <= '0;
      done_r  <= 1'b0;
    end else begin
      done_r <= accept_s || sweep_last_s;
      case (state_r)
        S_IDLE: begin
          if (clr) begin
            state_r <= S_CLEAR;
            cnt_r   <= CNT_ONE;
          end
        end
        S_CLEAR: begin
          if (sweep_last_s) begin
            state_r <= S_IDLE;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= S_IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign rd_x = rd_x_s;
  assign rd_y = rd_y_s;
  assign busy = (state_r == S_CLEAR);
  assign done = done_r;

endmodule

// File: tb/tb_rf_sync.sv
// tb_rf_sync: random and directed checks of rf_sync against an array model.
// Two instances share every input: one with bypass, one without.
module tb_rf_sync;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rd_addr_x, rd_addr_y, wr_addr;
  logic        req, wr_en, clr;
  logic [1:0]  wr_mode;
  logic [31:0] wr_data;
  logic [31:0] rd_x_b, rd_y_b, rd_x_n, rd_y_n;
  logic        busy_b, done_b, busy_n, done_n;

  int tests = 0;
  int fails = 0;
  logic [31:0] model [32];

  always #5 clk = ~clk;

  rf_sync #(.DW(32), .NREGS(32), .BYPASS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr_x(rd_addr_x), .rd_addr_y(rd_addr_y),
    .rd_x(rd_x_b), .rd_y(rd_y_b), .req(req), .wr_en(wr_en), .wr_mode(wr_mode),
    .wr_addr(wr_addr), .wr_data(wr_data), .clr(clr), .busy(busy_b), .done(done_b)
  );

  rf_sync #(.DW(32), .NREGS(32), .BYPASS(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .rd_addr_x(rd_addr_x), .rd_addr_y(rd_addr_y),
    .rd_x(rd_x_n), .rd_y(rd_y_n), .req(req), .wr_en(wr_en), .wr_mode(wr_mode),
    .wr_addr(wr_addr), .wr_data(wr_data), .clr(clr), .busy(busy_n), .done(done_n)
  );

  initial begin
    #300000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Value a register holds after a write in the given mode.
  function automatic logic [31:0] merge_ref(input logic [31:0] old, input logic [31:0] d,
                                            input logic [1:0] mode);
    case (mode)
      2'd0:    return d;
      2'd1:    return (old & 32'h0000_FFFF) | ((d & 32'h0000_FFFF) << 16);
      2'd2:    return (old & 32'hFFFF_0000) | (d & 32'h0000_FFFF);
      default: return old;
    endcase
  endfunction

  function automatic logic writes_now();
    return req && wr_en && (wr_addr != 5'd0) && (wr_mode != 2'd3);
  endfunction

  // Expected combinational read for an idle-state cycle.
  function automatic logic [31:0] exp_read(input logic [4:0] a, input logic byp);
    if (a == 5'd0) return 32'h0;
    if (byp && writes_now() && (a == wr_addr)) return merge_ref(model[a], wr_data, wr_mode);
    return model[a];
  endfunction

  task automatic idle_inputs();
    req = 1'b0; wr_en = 1'b0; wr_mode = 2'd0; wr_addr = 5'd0; wr_data = 32'h0; clr = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // One accepted operation: check reads (incl. bypass) before the edge, done after.
  task automatic op(input logic en, input logic [1:0] mode, input logic [4:0] a,
                    input logic [31:0] d, input logic [4:0] rx);
    logic [31:0] nv;
    logic        wr;
    req = 1'b1; wr_en = en; wr_mode = mode; wr_addr = a; wr_data = d;
    rd_addr_x = rx; rd_addr_y = a;
    #1;
    check("byp_rd_x", rd_x_b, exp_read(rx, 1'b1));
    check("byp_rd_y", rd_y_b, exp_read(a, 1'b1));
    check("nobyp_rd_x", rd_x_n, exp_read(rx, 1'b0));
    check("nobyp_rd_y", rd_y_n, exp_read(a, 1'b0));
    wr = writes_now();
    nv = merge_ref(model[a], d, mode);
    @(posedge clk); #1;
    if (wr) model[a] = nv;
    idle_inputs();
    check("done_b", {31'h0, done_b}, 32'h1);
    check("done_n", {31'h0, done_n}, 32'h1);
  endtask

  task automatic rd(input logic [4:0] x, input logic [4:0] y);
    rd_addr_x = x; rd_addr_y = y;
    #1;
    check("rd_x_b", rd_x_b, exp_read(x, 1'b0));
    check("rd_y_b", rd_y_b, exp_read(y, 1'b0));
    check("rd_x_n", rd_x_n, exp_read(x, 1'b0));
    check("rd_y_n", rd_y_n, exp_read(y, 1'b0));
  endtask

  task automatic tick_idle();
    idle_inputs();
    @(posedge clk); #1;
    check("done_idle", {31'h0, done_b}, 32'h0);
  endtask

  initial begin
    int busy_cycles;
    logic saw_done;

    // Reset state.
    rst_n = 1'b0;
    idle_inputs();
    clear_model();
    rd_addr_x = 5'd5; rd_addr_y = 5'd0;
    #2;
    check("rst_busy", {31'h0, busy_b}, 32'h0);
    check("rst_done", {31'h0, done_b}, 32'h0);
    check("rst_r5", rd_x_b, 32'h0);
    check("rst_r0", rd_y_n, 32'h0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Write modes.
    op(1'b1, 2'd0, 5'd3, 32'hDEAD_BEEF, 5'd3);
    rd(5'd3, 5'd0);
    op(1'b1, 2'd1, 5'd3, 32'h0000_1234, 5'd3);
    rd(5'd3, 5'd3);
    check("r3_upper", rd_x_n, 32'h1234_BEEF);
    op(1'b1, 2'd2, 5'd3, 32'h0000_ABCD, 5'd3);
    tick_idle();
    rd(5'd3, 5'd3);
    check("r3_lower", rd_x_n, 32'h1234_ABCD);

    // Zero register, no-write op, reserved mode.
    op(1'b1, 2'd0, 5'd0, 32'hFFFF_FFFF, 5'd0);
    rd(5'd0, 5'd0);
    op(1'b0, 2'd0, 5'd3, 32'h1111_1111, 5'd3);
    op(1'b1, 2'd3, 5'd3, 32'h2222_2222, 5'd3);
    rd(5'd3, 5'd0);
    check("r3_kept", rd_x_b, 32'h1234_ABCD);
    tick_idle();

    // Bypass versus stored value in the write cycle.
    req = 1'b1; wr_en = 1'b1; wr_mode = 2'd0; wr_addr = 5'd7; wr_data = 32'h55AA_55AA;
    rd_addr_x = 5'd7;
    #1;
    check("bypass_same_cycle", rd_x_b, 32'h55AA_55AA);
    check("nobypass_same_cycle", rd_x_n, 32'h0);
    @(posedge clk); #1;
    model[7] = 32'h55AA_55AA;
    idle_inputs();
    check("nobypass_next_cycle", rd_x_n, 32'h55AA_55AA);

    // Randomised operations, reads and idle gaps.
    for (int it = 0; it < 150; it++) begin
      op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
         $urandom, 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) tick_idle();
    end
    tick_idle();

    // Fill r1..r31 with nonzero data, then clear with a colliding req.
    for (int i = 1; i < 32; i++) op(1'b1, 2'd0, 5'(i), $urandom | 32'h1, 5'(i));
    clr = 1'b1; req = 1'b1; wr_en = 1'b1; wr_mode = 2'd0; wr_addr = 5'd5; wr_data = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    clr = 1'b0; wr_addr = 5'd2; wr_data = 32'hFFFF_FFFF;
    busy_cycles = 0;
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (busy_b) begin
        busy_cycles++;
        check("done_during_busy", {31'h0, done_b}, 32'h0);
        rd_addr_x = 5'd1; rd_addr_y = 5'd31;
        #1;
        if (busy_cycles >= 2) check("swept_r1", rd_x_n, 32'h0);
        check("unswept_r31", rd_y_n, model[31]);
        if (busy_cycles == 10) req = 1'b0;
      end else begin
        check("sweep_done", {31'h0, done_b}, 32'h1);
        saw_done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    check("busy_cycles", 32'(busy_cycles), 32'd31);
    check("sweep_done_seen", {31'h0, saw_done}, 32'h1);
    tick_idle();
    clear_model();
    for (int i = 0; i < 32; i++) rd(5'(i), 5'(31 - i));

    // Reset in the middle of a sweep, then a normal write.
    op(1'b1, 2'd0, 5'd4, 32'h4444_4444, 5'd0);
    op(1'b1, 2'd0, 5'd20, 32'h2020_2020, 5'd0);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
    end
    check("busy_before_abort", {31'h0, busy_b}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'h0, busy_b}, 32'h0);
    check("abort_done", {31'h0, done_b}, 32'h0);
    clear_model();
    rd(5'd20, 5'd4);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    op(1'b1, 2'd0, 5'd9, 32'hCAFE_F00D, 5'd9);
    rd(5'd9, 5'd20);
    check("r9_after_reset", rd_x_b, 32'hCAFE_F00D);
    check("busy_after_reset", {31'h0, busy_n}, 32'h0);
    tick_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
